lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Parametrised load/store unit for the MEM stage of the MINAv2 pipeline. It accepts one
//  mem_op_e request per access and runs a single-outstanding request/ack bus transaction.
//  It steers byte/half/word/dword lanes, sign- or zero-extends loads, and flags misaligned,
//  bus-error and timeout faults. It stalls the pipeline until the access retires.
// PARAMETERS
//  XLEN     32   datapath width; legal values are 32 and 64; STRB_W = XLEN/8
//  ADDR_W   32   bus address width
//  TIMEOUT  255  BUS-state cycles without ack before a timeout fault; 0 disables the timeout
// PORTS
//  clk           in   1        clock, rising edge
//  rst_n         in   1        asynchronous reset, active low
//  req_valid     in   1        request present from the EX/MEM register; held stable while stall=1
//  req_op        in   2        mem_op_e; MEM_OP_NONE means no access
//  req_size      in   2        mem_size_e: B=00, H=01, W=10, D=11 (D is legal only when XLEN=64)
//  req_signed    in   1        sign-extend load data
//  req_addr      in   ADDR_W   byte address
//  req_wdata     in   XLEN     store data, right-aligned
//  req_rd_addr   in   5        regaddr_t destination
//  flush         in   1        squash the current or pending access
//  stall         out  1        hold the upstream pipeline
//  bus_cyc       out  1        bus request active
//  bus_we        out  1        1 = write
//  bus_addr      out  ADDR_W   address aligned down to STRB_W
//  bus_wdata     out  XLEN     lane-replicated store data
//  bus_wrstb     out  STRB_W   byte write strobes; all zero on reads
//  bus_ack       in   1        transaction complete; may assert in the first bus_cyc cycle
//  bus_err       in   1        qualified by bus_ack
//  bus_rdata     in   XLEN     read data, valid with bus_ack
//  resp_valid    out  1        one-cycle retire pulse
//  resp_we       out  1        write resp_rdata to resp_rd_addr; 0 on stores and faults
//  resp_rd_addr  out  5        latched req_rd_addr
//  resp_rdata    out  XLEN     extended load data
//  exc_misalign  out  1        fault flag, valid with resp_valid
//  exc_bus       out  1        bus_err or timeout, valid with resp_valid
//  exc_addr      out  ADDR_W   faulting byte address
// BEHAVIOUR
//  Reset: every output is 0, state is IDLE, and the timeout counter is 0.
//   A reset mid-access drops bus_cyc asynchronously; the outstanding ack is ignored.
//  FSM states: IDLE, BUS, DONE.
//   IDLE -> BUS on accept, when req_valid && op!=NONE && aligned && !flush.
//   IDLE -> DONE on a misaligned or illegal-size request; no bus cycle is issued.
//   BUS  -> DONE on bus_ack, or when the timer reaches TIMEOUT.
//   DONE -> IDLE unconditionally.
//  stall = (IDLE && req_valid && op!=NONE && !flush) || BUS. stall is 0 in DONE, so the
//   pipeline advances. DONE ignores req_* to avoid re-accepting the held request.
//  Latency:
//   Accept in cycle 0; bus_cyc is registered and high from cycle 1.
//   bus_cyc falls on the edge after the ack.
//   resp_valid is high in the cycle after the ack; minimum 3 cycles per access.
//  Alignment rule: addr mod (1<<size) must be 0. For XLEN=32, size D is illegal and raises
//   exc_misalign.
//  Stores: wdata is replicated per lane. wrstb = ((1<<(1<<size))-1) << addr[log2(STRB_W)-1:0].
//  Loads: rdata lane is selected by the low address bits, then sign/zero-extended to XLEN.
//  Fault: resp_valid=1 with resp_we=0 and the exc flag set; exc_addr=req_addr. A timeout
//   reports exc_bus and withdraws bus_cyc.
//  flush:
//   In IDLE, blocks acceptance.
//   In BUS, the transaction still completes (no abort), but resp_valid, resp_we and the exc
//    flags are suppressed in DONE.
//   In DONE, suppresses resp_valid.
//  bus_addr, bus_we, bus_wdata and bus_wrstb are stable for the whole bus_cyc window.
// STRUCTURE
//  Add to the types package: mem_size_e, lsu_state_e {LSU_IDLE, LSU_BUS, LSU_DONE}, and
//   an lsu_req_t struct {op, size, signed, addr, wdata, rd_addr}.
//  Sub-module lsu_align (combinational): size/offset in -> wrstb, replicated wdata, extended
//   rdata, misalign flag.
// TESTING
//  1. LW addr 0x100, ack in cycle 1, rdata 0xDEADBEEF -> resp_rdata=0xDEADBEEF, resp_we=1,
//     resp_valid in cycle 2.
//  2. LB signed addr 0x103, rdata 0x80112233 -> 0xFFFFFF80. LBU of the same -> 0x00000080.
//  3. SH addr 0x102, wdata 0x1234 -> bus_wdata=0x12341234, wrstb=4'b1100, resp_we=0.
//  4. LW addr 0x101 -> no bus_cyc, DONE next cycle, exc_misalign=1, exc_addr=0x101.
//  5. No ack, TIMEOUT=4 -> bus_cyc high 4 cycles, then exc_bus=1. bus_err with ack -> exc_bus=1.
//  6. flush in BUS -> bus completes, resp_valid=0. rst_n low in BUS -> bus_cyc=0 immediately.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the MEM-stage load/store unit.
package lsu_ctrl_pkg;

    // Widest datapath/address the request bundle has to carry; narrower
    // instances zero-extend into it and ignore the upper bits.
    localparam int LSU_XLEN_MAX = 64;
    localparam int LSU_ADDR_MAX = 64;

    // MEM_OP_RSVD is not produced by the decoder; it behaves as a load.
    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'b00,
        MEM_OP_LOAD  = 2'b01,
        MEM_OP_STORE = 2'b10,
        MEM_OP_RSVD  = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'b00,
        MEM_SIZE_H = 2'b01,
        MEM_SIZE_W = 2'b10,
        MEM_SIZE_D = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_BUS  = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_e;

    typedef logic [4:0] regaddr_t;

    typedef struct packed {
        mem_op_e                  op;
        mem_size_e                size;
        logic                     is_signed;
        logic [LSU_ADDR_MAX-1:0]  addr;
        logic [LSU_XLEN_MAX-1:0]  wdata;
        regaddr_t                 rd_addr;
    } lsu_req_t;

    // Contiguous byte-enable pattern for an access of the given size,
    // before it is shifted to its lane.
    function automatic logic [7:0] lsu_byte_mask(input mem_size_e size);
        logic [7:0] mask;
        case (size)
            MEM_SIZE_B: mask = 8'h01;
            MEM_SIZE_H: mask = 8'h03;
            MEM_SIZE_W: mask = 8'h0F;
            default:    mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Lane steering for the load/store unit: store strobes and replication,
// load lane extraction with sign/zero extension, and the alignment check.
module lsu_ctrl_align
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mem_size_e                      size_i,
    input  logic [$clog2(XLEN/8)-1:0]      offset_i,
    input  logic                           sign_i,
    input  logic [XLEN-1:0]                wdata_i,
    input  logic [XLEN-1:0]                rdata_i,
    output logic [XLEN/8-1:0]              wrstb_o,
    output logic [XLEN-1:0]                wdata_o,
    output logic [XLEN-1:0]                rdata_o,
    output logic                           misalign_o
);

    localparam int STRB_W = XLEN / 8;

    logic [STRB_W-1:0] mask;
    logic [XLEN-1:0]   shifted;

    // Store side: replicate the right-aligned data into every lane and place
    // the strobes; flag any address that is not a multiple of the size.
    always_comb begin
        misalign_o = 1'b0;
        wdata_o    = wdata_i;
        mask       = STRB_W'(lsu_byte_mask(size_i));
        case (size_i)
            MEM_SIZE_B: begin
                wdata_o = {STRB_W{wdata_i[7:0]}};
            end
            MEM_SIZE_H: begin
                misalign_o = offset_i[0];
                wdata_o    = {(XLEN/16){wdata_i[15:0]}};
            end
            MEM_SIZE_W: begin
                misalign_o = |offset_i[1:0];
                wdata_o    = {(XLEN/32){wdata_i[31:0]}};
            end
            default: begin
                // A doubleword only exists on a 64-bit datapath.
                misalign_o = (XLEN != 64) || (|offset_i);
                wdata_o    = wdata_i;
            end
        endcase
        wrstb_o = mask << offset_i;
    end

    // Load side: bring the addressed lane down to bit 0 and extend it.
    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        rdata_o = shifted;
        case (size_i)
            MEM_SIZE_B: begin
                if (sign_i) rdata_o = XLEN'($signed(shifted[7:0]));
                else        rdata_o = XLEN'(shifted[7:0]);
            end
            MEM_SIZE_H: begin
                if (sign_i) rdata_o = XLEN'($signed(shifted[15:0]));
                else        rdata_o = XLEN'(shifted[15:0]);
            end
            MEM_SIZE_W: begin
                if (sign_i) rdata_o = XLEN'($signed(shifted[31:0]));
                else        rdata_o = XLEN'(shifted[31:0]);
            end
            default: begin
                rdata_o = shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store unit: one outstanding request/ack bus access at a
// time, lane steering, load extension and misalign/bus/timeout faults.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   LSU_IDLE | waiting for a request; misaligned ones go straight to DONE
//   LSU_BUS  | bus_cyc high, waiting for bus_ack or the timeout
//   LSU_DONE | one-cycle retire: response/fault flags presented, stall low
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic [1:0]           req_op,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [4:0]           req_rd_addr,
    input  logic                 flush,
    output logic                 stall,
    output logic                 bus_cyc,
    output logic                 bus_we,
    output logic [ADDR_W-1:0]    bus_addr,
    output logic [XLEN-1:0]      bus_wdata,
    output logic [XLEN/8-1:0]    bus_wrstb,
    input  logic                 bus_ack,
    input  logic                 bus_err,
    input  logic [XLEN-1:0]      bus_rdata,
    output logic                 resp_valid,
    output logic                 resp_we,
    output logic [4:0]           resp_rd_addr,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 exc_misalign,
    output logic                 exc_bus,
    output logic [ADDR_W-1:0]    exc_addr
);

    localparam int STRB_W   = XLEN / 8;
    localparam int OFF_W    = $clog2(STRB_W);
    localparam int TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // The timer counts down from TIMEOUT-1 so that terminal count is reached
    // in the TIMEOUT-th bus cycle without an ack.
    localparam int TMR_LOAD = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    lsu_state_e         state_q;
    lsu_req_t           req_d, req_q;
    logic [TMR_W-1:0]   tmr_q;
    logic               flush_q;

    logic               bus_cyc_q, bus_we_q;
    logic [ADDR_W-1:0]  bus_addr_q;
    logic [XLEN-1:0]    bus_wdata_q;
    logic [STRB_W-1:0]  bus_wrstb_q;

    logic               resp_valid_q, resp_we_q;
    logic [4:0]         resp_rd_addr_q;
    logic [XLEN-1:0]    resp_rdata_q;
    logic               exc_misalign_q, exc_bus_q;
    logic [ADDR_W-1:0]  exc_addr_q;

    logic               req_go, req_is_store, q_is_store;
    logic               tmo, bus_fault, keep;

    mem_size_e          al_size;
    logic [OFF_W-1:0]   al_off;
    logic [STRB_W-1:0]  al_wrstb;
    logic [XLEN-1:0]    al_wdata, al_rdata;
    logic               al_misalign;

    // Upper bits of the wide request bundle are never used on narrow builds.
    logic               unused_req;
    assign unused_req = ^{req_q.wdata, req_q.addr};

    // Bundle the incoming request.
    always_comb begin
        req_d           = '0;
        req_d.op        = mem_op_e'(req_op);
        req_d.size      = mem_size_e'(req_size);
        req_d.is_signed = req_signed;
        req_d.addr      = LSU_ADDR_MAX'(req_addr);
        req_d.wdata     = LSU_XLEN_MAX'(req_wdata);
        req_d.rd_addr   = req_rd_addr;
    end

    // Handshake terms and the lane-steering input select: in IDLE the aligner
    // looks at the incoming request, afterwards at the latched one.
    always_comb begin
        req_go       = (state_q == LSU_IDLE) && req_valid
                       && (req_d.op != MEM_OP_NONE) && !flush;
        req_is_store = (req_d.op == MEM_OP_STORE);
        q_is_store   = (req_q.op == MEM_OP_STORE);
        tmo          = (TIMEOUT != 0) && (tmr_q == '0);
        bus_fault    = bus_ack ? bus_err : 1'b1;
        keep         = !(flush_q || flush);
        if (state_q == LSU_IDLE) begin
            al_size = req_d.size;
            al_off  = req_addr[OFF_W-1:0];
        end else begin
            al_size = req_q.size;
            al_off  = req_q.addr[OFF_W-1:0];
        end
    end

    lsu_ctrl_align #(
        .XLEN (XLEN)
    ) u_align (
        .size_i     (al_size),
        .offset_i   (al_off),
        .sign_i     (req_q.is_signed),
        .wdata_i    (req_wdata),
        .rdata_i    (bus_rdata),
        .wrstb_o    (al_wrstb),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

    // Access sequencer: accept, run the bus cycle, retire for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= LSU_IDLE;
            req_q          <= '0;
            tmr_q          <= '0;
            flush_q        <= 1'b0;
            bus_cyc_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            bus_wrstb_q    <= '0;
            resp_valid_q   <= 1'b0;
            resp_we_q      <= 1'b0;
            resp_rd_addr_q <= '0;
            resp_rdata_q   <= '0;
            exc_misalign_q <= 1'b0;
            exc_bus_q      <= 1'b0;
            exc_addr_q     <= '0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (req_go) begin
                        req_q <= req_d;
                        if (al_misalign) begin
                            state_q        <= LSU_DONE;
                            resp_valid_q   <= 1'b1;
                            resp_rd_addr_q <= req_rd_addr;
                            exc_misalign_q <= 1'b1;
                            exc_addr_q     <= req_addr;
                        end else begin
                            state_q     <= LSU_BUS;
                            bus_cyc_q   <= 1'b1;
                            bus_we_q    <= req_is_store;
                            bus_addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            bus_wdata_q <= req_is_store ? al_wdata : '0;
                            bus_wrstb_q <= req_is_store ? al_wrstb : '0;
                            tmr_q       <= TMR_W'(TMR_LOAD);
                            flush_q     <= 1'b0;
                        end
                    end
                end
                LSU_BUS: begin
                    if (bus_ack || tmo) begin
                        // A flush seen at any point in the bus window keeps
                        // the access from retiring architecturally.
                        state_q        <= LSU_DONE;
                        bus_cyc_q      <= 1'b0;
                        bus_we_q       <= 1'b0;
                        bus_addr_q     <= '0;
                        bus_wdata_q    <= '0;
                        bus_wrstb_q    <= '0;
                        resp_valid_q   <= keep;
                        resp_we_q      <= keep && !bus_fault && !q_is_store;
                        resp_rd_addr_q <= keep ? req_q.rd_addr : '0;
                        resp_rdata_q   <= (keep && !bus_fault && !q_is_store) ? al_rdata : '0;
                        exc_bus_q      <= keep && bus_fault;
                        exc_addr_q     <= (keep && bus_fault) ? req_q.addr[ADDR_W-1:0] : '0;
                    end else begin
                        flush_q <= flush_q || flush;
                        if (TIMEOUT != 0) tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                LSU_DONE: begin
                    state_q        <= LSU_IDLE;
                    tmr_q          <= '0;
                    flush_q        <= 1'b0;
                    resp_valid_q   <= 1'b0;
                    resp_we_q      <= 1'b0;
                    resp_rd_addr_q <= '0;
                    resp_rdata_q   <= '0;
                    exc_misalign_q <= 1'b0;
                    exc_bus_q      <= 1'b0;
                    exc_addr_q     <= '0;
                end
                default: begin
                    state_q <= LSU_IDLE;
                end
            endcase
        end
    end

    // A flush arriving during the retire cycle still squashes the response.
    assign stall        = req_go || (state_q == LSU_BUS);
    assign bus_cyc      = bus_cyc_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_wrstb    = bus_wrstb_q;
    assign resp_valid   = resp_valid_q && !flush;
    assign resp_we      = resp_we_q;
    assign resp_rd_addr = resp_rd_addr_q;
    assign resp_rdata   = resp_rdata_q;
    assign exc_misalign = exc_misalign_q;
    assign exc_bus      = exc_bus_q;
    assign exc_addr     = exc_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl (XLEN=32, TIMEOUT=4).
module tb_lsu_ctrl;

    localparam int XLEN = 32;
    localparam int ADDR_W = 32;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = '0;
    logic [1:0]  req_size = '0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd_addr = '0;
    logic        flush = 1'b0;
    logic        stall, bus_cyc, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wrstb;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        resp_valid, resp_we;
    logic [4:0]  resp_rd_addr;
    logic [31:0] resp_rdata;
    logic        exc_misalign, exc_bus;
    logic [31:0] exc_addr;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd_addr(req_rd_addr), .flush(flush), .stall(stall),
        .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wrstb(bus_wrstb), .bus_ack(bus_ack),
        .bus_err(bus_err), .bus_rdata(bus_rdata), .resp_valid(resp_valid),
        .resp_we(resp_we), .resp_rd_addr(resp_rd_addr), .resp_rdata(resp_rdata),
        .exc_misalign(exc_misalign), .exc_bus(exc_bus), .exc_addr(exc_addr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: byte-level view of the bus lanes.
    function automatic logic [31:0] m_lanes(input logic [31:0] wd, input int size);
        int nb;
        logic [31:0] r;
        nb = 1 << size;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] m_strb(input logic [31:0] addr, input int size);
        int s;
        s = ((1 << (1 << size)) - 1) << (addr % 4);
        return s[3:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] addr,
                                           input int size, input logic sgn);
        int nb;
        logic [63:0] v, m;
        nb = 1 << size;
        v = {32'h0, rd} >> (8 * (addr % 4));
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (sgn && v[8*nb-1]) v = v | ~m;
        return v[31:0];
    endfunction

    // One access: dly = BUS cycle index of the ack (>= TO means no ack),
    // fl_bus = BUS cycle index carrying flush (-1 none), fl_done = flush in retire cycle.
    task automatic access(input logic [1:0] op, input int size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input int dly, input logic err, input logic [31:0] rdata,
                          input int fl_bus, input logic fl_done);
        bit mis, st, tmo, sup, e, ev;
        int nbus;
        mis = (size == 3) || ((addr % (32'd1 << size)) != 0);
        st  = (op == 2'd2);
        req_valid = 1'b1; req_op = op; req_size = size[1:0]; req_signed = sgn;
        req_addr = addr; req_wdata = wd; req_rd_addr = rd; flush = 1'b0;
        @(negedge clk);
        chk("stall_accept", stall, 1);
        chk("cyc_accept", bus_cyc, 0);
        @(posedge clk); #1;
        if (mis) begin
            flush = fl_done;
            @(negedge clk);
            chk("mis_cyc", bus_cyc, 0);
            chk("mis_stall", stall, 0);
            chk("mis_valid", resp_valid, !fl_done);
            chk("mis_flag", exc_misalign, 1);
            chk("mis_addr", exc_addr, addr);
            chk("mis_we", resp_we, 0);
            chk("mis_bus", exc_bus, 0);
        end else begin
            tmo  = (dly >= TO);
            nbus = tmo ? TO : dly + 1;
            for (int k = 0; k < nbus; k++) begin
                bus_ack   = (k == dly);
                bus_err   = (k == dly) && err;
                bus_rdata = (k == dly) ? rdata : $urandom;
                flush     = (k == fl_bus);
                @(negedge clk);
                chk("bus_cyc", bus_cyc, 1);
                chk("bus_stall", stall, 1);
                chk("bus_we", bus_we, st);
                chk("bus_addr", bus_addr, addr & ~32'd3);
                chk("bus_wrstb", bus_wrstb, st ? m_strb(addr, size) : 4'h0);
                if (st) chk("bus_wdata", bus_wdata, m_lanes(wd, size));
                @(posedge clk); #1;
            end
            bus_ack = 1'b0; bus_err = 1'b0; flush = fl_done;
            @(negedge clk);
            sup = (fl_bus >= 0) && (fl_bus < nbus);
            e   = tmo || err;
            ev  = !sup && !fl_done;
            chk("done_cyc", bus_cyc, 0);
            chk("done_stall", stall, 0);
            chk("done_valid", resp_valid, ev);
            chk("done_mis", exc_misalign, 0);
            if (!sup) begin
                chk("done_we", resp_we, !st && !e);
                chk("done_exc_bus", exc_bus, e);
                chk("done_rd", resp_rd_addr, rd);
                if (!st && !e) chk("done_rdata", resp_rdata, m_load(rdata, addr, size, sgn));
                if (e) chk("done_exc_addr", exc_addr, addr);
            end else begin
                chk("flush_we", resp_we, 0);
                chk("flush_exc_bus", exc_bus, 0);
            end
        end
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0; req_op = 2'd0;
        @(negedge clk);
        chk("gap_valid", resp_valid, 0);
        chk("gap_cyc", bus_cyc, 0);
        chk("gap_stall", stall, 0);
        @(posedge clk); #1;
    endtask

    // Request that must not be accepted (op NONE or flushed in IDLE).
    task automatic no_accept(input logic [1:0] op, input logic fl);
        req_valid = 1'b1; req_op = op; req_size = 2'd2; req_addr = 32'h40; flush = fl;
        @(negedge clk);
        chk("noacc_stall", stall, 0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'd0; flush = 1'b0;
        @(negedge clk);
        chk("noacc_cyc", bus_cyc, 0);
        chk("noacc_valid", resp_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int op, size, dly, flb;
        logic [31:0] addr;

        #2;
        chk("rst_stall", stall, 0);
        chk("rst_cyc", bus_cyc, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_wrstb", bus_wrstb, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_rwe", resp_we, 0);
        chk("rst_rd", resp_rd_addr, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_mis", exc_misalign, 0);
        chk("rst_bus", exc_bus, 0);
        chk("rst_eaddr", exc_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        access(2'd1, 2, 1'b0, 32'h100, 32'h0, 5'd5, 0, 1'b0, 32'hDEADBEEF, -1, 1'b0);
        access(2'd1, 0, 1'b1, 32'h103, 32'h0, 5'd6, 0, 1'b0, 32'h80112233, -1, 1'b0);
        access(2'd1, 0, 1'b0, 32'h103, 32'h0, 5'd7, 1, 1'b0, 32'h80112233, -1, 1'b0);
        access(2'd2, 1, 1'b0, 32'h102, 32'h1234, 5'd8, 0, 1'b0, 32'h0, -1, 1'b0);
        access(2'd1, 2, 1'b0, 32'h101, 32'h0, 5'd9, 0, 1'b0, 32'h0, -1, 1'b0);
        access(2'd1, 3, 1'b0, 32'h108, 32'h0, 5'd9, 0, 1'b0, 32'h0, -1, 1'b0);
        access(2'd1, 2, 1'b0, 32'h200, 32'h0, 5'd10, TO, 1'b0, 32'h0, -1, 1'b0);
        access(2'd2, 2, 1'b0, 32'h204, 32'hCAFEF00D, 5'd11, 2, 1'b1, 32'h0, -1, 1'b0);
        access(2'd1, 1, 1'b1, 32'h206, 32'h0, 5'd12, 1, 1'b0, 32'h00008001, 0, 1'b0);
        access(2'd1, 2, 1'b0, 32'h300, 32'h0, 5'd13, 0, 1'b0, 32'h12345678, -1, 1'b1);
        access(2'd1, 2, 1'b0, 32'h304, 32'h0, 5'd14, 3, 1'b0, 32'h0BADF00D, -1, 1'b0);
        no_accept(2'd0, 1'b0);
        no_accept(2'd1, 1'b1);

        // Randomised accesses against the model.
        for (int n = 0; n < 80; n++) begin
            op   = $urandom_range(0, 1) ? 1 : 2;
            size = $urandom_range(0, 3);
            addr = $urandom & 32'h0000_FFFF;
            if (size < 3 && ($urandom % 4) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            dly  = $urandom_range(0, 5);
            flb  = (($urandom % 8) == 0) ? $urandom_range(0, 3) : -1;
            access(op[1:0], size, 1'($urandom), addr, $urandom, 5'($urandom), dly,
                   (($urandom % 6) == 0), $urandom, flb, (($urandom % 10) == 0));
        end

        // Reset in the middle of a bus cycle.
        req_valid = 1'b1; req_op = 2'd1; req_size = 2'd2; req_addr = 32'h400; flush = 1'b0;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre", bus_cyc, 1);
        #2;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0;
        #1;
        chk("rst_mid_cyc", bus_cyc, 0);
        chk("rst_mid_stall", stall, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
        @(negedge clk);
        chk("rst_late_cyc", bus_cyc, 0);
        chk("rst_late_valid", resp_valid, 0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("rst_late_valid2", resp_valid, 0);
        @(posedge clk); #1;

        // Unit still functional after the reset.
        access(2'd1, 2, 1'b0, 32'h500, 32'h0, 5'd3, 0, 1'b0, 32'hA5A5A5A5, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
